// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline stage register carrying one packed stage bundle, with a valid/ready
// handshake, an optional two-entry skid buffer, and flush/hold/bubble pipeline control.
module pipe_stage_elastic #(
    parameter int                DATA_W      = 32,
    parameter logic [DATA_W-1:0] DEFAULT_VAL = '0,
    parameter bit                SKID_EN     = 1'b1,
    parameter int                HOLD_W      = 3,
    parameter int                STAGE_IDX   = 2
) (
    input  logic              sys_clk,
    input  logic              sys_arstn,
    input  logic              flag_flush,
    input  logic [HOLD_W-1:0] flag_hold,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] data_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] data_out,
    output logic [1:0]        occupancy
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] head_q, head_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              in_ready_q, in_ready_d;
    logic              run_q;

    logic hold;
    logic bubble;
    logic accept;
    logic emit;

    assign hold = flag_hold[STAGE_IDX];

    // The bubble bit belongs to the stage feeding us; stage 0 has no upstream stage.
    generate
        if (STAGE_IDX == 0) begin : g_no_bubble
            assign bubble = 1'b0;
        end else begin : g_bubble
            assign bubble = flag_hold[STAGE_IDX-1];
        end
    endgenerate

    // Only two bits of the shared vector are meaningful to this stage.
    logic unused_hold_bits;
    assign unused_hold_bits = ^flag_hold;

    assign accept = in_valid & in_ready & ~bubble & ~hold & ~flag_flush;
    assign emit   = out_valid & out_ready & ~hold & ~flag_flush;

    // State register
    always_ff @(posedge sys_clk or negedge sys_arstn) begin
        if (!sys_arstn) begin
            state_q    <= S_EMPTY;
            head_q     <= DEFAULT_VAL;
            skid_q     <= DEFAULT_VAL;
            in_ready_q <= 1'b0;
            run_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
            run_q      <= 1'b1;
        end
    end

    // Next-state logic; hold needs no branch of its own since it forces accept=emit=0.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        if (flag_flush) begin
            state_d = S_EMPTY;
            head_d  = DEFAULT_VAL;
            skid_d  = DEFAULT_VAL;
        end else begin
            unique case (state_q)
                S_EMPTY: begin
                    if (accept) begin
                        state_d = S_ONE;
                        head_d  = data_in;
                    end
                end
                S_ONE: begin
                    if (accept && !emit) begin
                        if (SKID_EN) begin
                            state_d = S_TWO;
                            skid_d  = data_in;
                        end else begin
                            head_d  = data_in;
                        end
                    end else if (emit && !accept) begin
                        state_d = S_EMPTY;
                        head_d  = DEFAULT_VAL;
                    end else if (emit && accept) begin
                        head_d  = data_in;
                    end
                end
                S_TWO: begin
                    if (emit) begin
                        state_d = S_ONE;
                        head_d  = skid_q;
                        skid_d  = DEFAULT_VAL;
                    end
                end
                default: begin
                    state_d = S_EMPTY;
                    head_d  = DEFAULT_VAL;
                    skid_d  = DEFAULT_VAL;
                end
            endcase
        end
        in_ready_d = (state_d != S_TWO);
    end

    // Outputs; run_q keeps the combinational ready low while reset is asserted.
    always_comb begin
        out_valid = (state_q != S_EMPTY);
        data_out  = out_valid ? head_q : DEFAULT_VAL;
        occupancy = state_q;
        if (SKID_EN) begin
            in_ready = in_ready_q;
        end else begin
            in_ready = run_q & ((state_q == S_EMPTY) | (out_ready & ~hold));
        end
    end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed self-checking bench for pipe_stage_elastic with default parameters
// (DATA_W=32, DEFAULT_VAL=0, SKID_EN=1, HOLD_W=3, STAGE_IDX=2).
module tb_pipe_stage_elastic;

    logic        sys_clk = 1'b0;
    logic        sys_arstn;
    logic        flag_flush;
    logic [2:0]  flag_hold;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] data_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] data_out;
    logic [1:0]  occupancy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 sys_clk = ~sys_clk;

    pipe_stage_elastic dut (
        .sys_clk   (sys_clk),
        .sys_arstn (sys_arstn),
        .flag_flush(flag_flush),
        .flag_hold (flag_hold),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .occupancy (occupancy)
    );

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Checks the full visible state: data_out, out_valid, occupancy, in_ready.
    task automatic chk_all(input string tag, input logic [31:0] d, input logic v,
                           input logic [1:0] occ, input logic rdy);
        chk({tag, ".data_out"},  data_out,           d);
        chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, v});
        chk({tag, ".occupancy"}, {30'd0, occupancy}, {30'd0, occ});
        chk({tag, ".in_ready"},  {31'd0, in_ready},  {31'd0, rdy});
        $display("step %-8s data_out=%h out_valid=%0b occ=%0d in_ready=%0b",
                 tag, data_out, out_valid, occupancy, in_ready);
    endtask

    initial begin
        sys_arstn  = 1'b0;
        flag_flush = 1'b0;
        flag_hold  = 3'b000;
        in_valid   = 1'b0;
        data_in    = 32'h0;
        out_ready  = 1'b0;

        // Reset asserted, then released away from the edge
        tick();
        tick();
        chk_all("in_rst", 32'h0, 1'b0, 2'd0, 1'b0);
        sys_arstn = 1'b1;
        tick();
        chk_all("rst_rel", 32'h0, 1'b0, 2'd0, 1'b1);

        // Back-to-back stream with out_ready=1
        out_ready = 1'b1;
        in_valid  = 1'b1;
        data_in   = 32'h11; tick(); chk_all("s11", 32'h11, 1'b1, 2'd1, 1'b1);
        data_in   = 32'h22; tick(); chk_all("s22", 32'h22, 1'b1, 2'd1, 1'b1);
        data_in   = 32'h33; tick(); chk_all("s33", 32'h33, 1'b1, 2'd1, 1'b1);
        in_valid  = 1'b0;   tick(); chk_all("sdrain", 32'h0, 1'b0, 2'd0, 1'b1);

        // Fill skid buffer with downstream stalled, then drain in order
        out_ready = 1'b0;
        in_valid  = 1'b1;
        data_in   = 32'hA; tick(); chk_all("fA", 32'hA, 1'b1, 2'd1, 1'b1);
        data_in   = 32'hB; tick(); chk_all("fB", 32'hA, 1'b1, 2'd2, 1'b0);
        data_in   = 32'hC; tick(); chk_all("fCoff", 32'hA, 1'b1, 2'd2, 1'b0);
        out_ready = 1'b1;
        tick(); chk_all("dB", 32'hB, 1'b1, 2'd1, 1'b1);
        tick(); chk_all("dC", 32'hC, 1'b1, 2'd1, 1'b1);
        in_valid  = 1'b0;
        tick(); chk_all("dempty", 32'h0, 1'b0, 2'd0, 1'b1);

        // Hold freezes the stage even with traffic offered on both sides
        out_ready = 1'b0;
        in_valid  = 1'b1;
        data_in   = 32'h44; tick(); chk_all("h44", 32'h44, 1'b1, 2'd1, 1'b1);
        flag_hold = 3'b100;
        out_ready = 1'b1;
        data_in   = 32'h45;
        for (int i = 0; i < 3; i++) begin
            tick(); chk_all("hold", 32'h44, 1'b1, 2'd1, 1'b1);
        end

        // Bubble: input ignored, head drains
        flag_hold = 3'b010;
        data_in   = 32'h55;
        tick(); chk_all("bub1", 32'h0, 1'b0, 2'd0, 1'b1);
        tick(); chk_all("bub2", 32'h0, 1'b0, 2'd0, 1'b1);

        // Flush beats hold and blocks the simultaneous input
        flag_hold = 3'b000;
        out_ready = 1'b0;
        data_in   = 32'h66; tick(); chk_all("p66", 32'h66, 1'b1, 2'd1, 1'b1);
        data_in   = 32'h77; tick(); chk_all("p77", 32'h66, 1'b1, 2'd2, 1'b0);
        flag_flush = 1'b1;
        flag_hold  = 3'b100;
        data_in    = 32'h88;
        tick(); chk_all("flush", 32'h0, 1'b0, 2'd0, 1'b1);
        flag_flush = 1'b0;
        flag_hold  = 3'b000;
        in_valid   = 1'b0;
        tick(); chk_all("postfl", 32'h0, 1'b0, 2'd0, 1'b1);

        // Asynchronous reset mid-transfer discards the entry immediately
        in_valid = 1'b1;
        data_in  = 32'h99; tick(); chk_all("p99", 32'h99, 1'b1, 2'd1, 1'b1);
        in_valid  = 1'b0;
        sys_arstn = 1'b0;
        #1;
        chk_all("arst", 32'h0, 1'b0, 2'd0, 1'b0);
        tick();
        sys_arstn = 1'b1;
        tick(); chk_all("arstrel", 32'h0, 1'b0, 2'd0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
